// File: rtl/bitfuscnn_pkg.sv
// Shared types for the output-activation sparse encoder path.
package bitfuscnn_pkg;

  localparam int OA_VALUE_WIDTH = 8;
  localparam int OA_INDEX_WIDTH = 4;
  // Longest zero run one index field can express.
  localparam int RUN_MAX = (1 << OA_INDEX_WIDTH) - 1;

  // One compressed OARAM entry: activation value plus zeros skipped before it.
  typedef struct packed {
    logic [OA_VALUE_WIDTH-1:0] value;
    logic [OA_INDEX_WIDTH-1:0] index;
  } oa_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/oa_zero_run_counter.sv
// Zero-run tracker: counts skipped zero activations and decides when an
// accepted activation produces an OARAM entry (nonzero value or saturated run).
module oa_zero_run_counter #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   accept,
  input  logic                   is_zero,
  input  logic                   clear,
  output logic                   emit,
  output logic [INDEX_WIDTH-1:0] run_index
);

  localparam logic [INDEX_WIDTH-1:0] RUN_MAX_L = {INDEX_WIDTH{1'b1}};
  localparam logic [INDEX_WIDTH-1:0] ONE_L     = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

  logic [INDEX_WIDTH-1:0] zrun;
  logic                   saturated;

  assign saturated = (zrun == RUN_MAX_L);
  assign run_index = zrun;

  // Emit on a nonzero value, or on a zero that would overflow the index field.
  always_comb begin
    emit = 1'b0;
    if (accept) begin
      emit = (!is_zero) || saturated;
    end else begin
      emit = 1'b0;
    end
  end

  // Zero-run register: restarts after every emit and at group end.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      zrun <= {INDEX_WIDTH{1'b0}};
    end else if (clear) begin
      zrun <= {INDEX_WIDTH{1'b0}};
    end else if (accept) begin
      if (emit) begin
        zrun <= {INDEX_WIDTH{1'b0}};
      end else begin
        zrun <= zrun + ONE_L;
      end
    end
  end

endmodule

// File: rtl/oa_sparse_encoder.sv
// Sparse encoder for one channel group of output activations: compresses the
// dense stream into (value, zero-run) entries written to sequential OARAM
// addresses and pulses group_done when the group is fully written.
// Build option: define OA_ENCODER_RELU_EN to clamp negative activations to
// zero before zero detection (fused ReLU).
module oa_sparse_encoder
  import bitfuscnn_pkg::*;
#(
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VALUE_WIDTH-1:0] in_value,
  input  logic                   in_last,
  input  logic                   oaram_ready,
  output logic [VALUE_WIDTH-1:0] oaram_value,
  output logic [INDEX_WIDTH-1:0] oaram_indices_value,
  output logic [RAM_WIDTH-2:0]   oaram_address,
  output logic                   oaram_write_enable,
  output logic                   group_done,
  output logic [RAM_WIDTH-2:0]   entry_count,
  output logic                   overflow
);

  localparam int AW = RAM_WIDTH - 1;
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  enc_state_t             state;
  logic                   in_xfer;
  logic                   out_xfer;
  logic                   is_zero;
  logic                   emit;
  logic                   zrun_clear;
  logic                   new_group;
  logic [VALUE_WIDTH-1:0] value_eff;
  logic [INDEX_WIDTH-1:0] run_index;

  // A new input is taken only when the single output slot is free or draining.
  assign in_ready   = (state != DONE) && (!oaram_write_enable || oaram_ready);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = oaram_write_enable && oaram_ready;
  assign zrun_clear = (state == DONE) && !oaram_write_enable;

`ifdef OA_ENCODER_RELU_EN
  assign value_eff = in_value[VALUE_WIDTH-1] ? {VALUE_WIDTH{1'b0}} : in_value;
`else
  assign value_eff = in_value;
`endif

  assign is_zero = (value_eff == {VALUE_WIDTH{1'b0}});

  oa_zero_run_counter #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_zero_run (
    .clk      (clk),
    .reset_n  (reset_n),
    .accept   (in_xfer),
    .is_zero  (is_zero),
    .clear    (zrun_clear),
    .emit     (emit),
    .run_index(run_index)
  );

  // Group FSM, output entry register, address/count tracking and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= IDLE;
      oaram_write_enable  <= 1'b0;
      oaram_value         <= {VALUE_WIDTH{1'b0}};
      oaram_indices_value <= {INDEX_WIDTH{1'b0}};
      oaram_address       <= {AW{1'b0}};
      entry_count         <= {AW{1'b0}};
      group_done          <= 1'b0;
      overflow            <= 1'b0;
      new_group           <= 1'b1;
    end else begin
      group_done <= 1'b0;

      // A fresh emit reloads the slot even while the old entry drains.
      if (emit) begin
        oaram_write_enable  <= 1'b1;
        oaram_value         <= value_eff;
        oaram_indices_value <= run_index;
      end else if (out_xfer) begin
        oaram_write_enable  <= 1'b0;
      end

      if (out_xfer) begin
        oaram_address <= oaram_address + ADDR_ONE;
        if (oaram_address == ADDR_MAX) begin
          overflow <= 1'b1;
        end
        entry_count <= new_group ? ADDR_ONE : (entry_count + ADDR_ONE);
        new_group   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in_xfer) begin
            state <= in_last ? DONE : RUN;
          end
        end
        RUN: begin
          if (in_xfer && in_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          // No write can be in flight here, so the address reset cannot race an increment.
          if (!oaram_write_enable) begin
            group_done    <= 1'b1;
            oaram_address <= {AW{1'b0}};
            state         <= IDLE;
            new_group     <= 1'b1;
            if (new_group) begin
              entry_count <= {AW{1'b0}};
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
